// File: rtl/jk_neg_driver_pkg.sv
// Shared definitions for the JK negative-edge flop driver.
//   - (invJ,invK) command encodings
//   - controller state enumeration
//   - the six-entry step table and its length
package jk_neg_driver_pkg;

   // Commands are the (invJ,invK) pair, both active-low.
   localparam logic [1:0] CMD_RESET  = 2'b10;
   localparam logic [1:0] CMD_HOLD   = 2'b11;
   localparam logic [1:0] CMD_SET    = 2'b01;
   localparam logic [1:0] CMD_TOGGLE = 2'b00;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   localparam int STEP_LEN = 6;

   // Step 0 is RESET, so the expected Q is defined after the first fall.
   localparam logic [1:0] STEP_TABLE [STEP_LEN] = '{
      CMD_RESET, CMD_HOLD, CMD_SET, CMD_HOLD, CMD_TOGGLE, CMD_TOGGLE
   };

   function automatic logic [1:0] stepCmd(input logic [2:0] idx);
      logic [1:0] r;
      r = CMD_HOLD;
      if (int'(idx) < STEP_LEN) r = STEP_TABLE[idx];
      return r;
   endfunction

   // Next flop state for a given command.
   function automatic logic nextQ(input logic [1:0] cmd, input logic q);
      logic r;
      case (cmd)
         CMD_RESET:  r = 1'b0;
         CMD_SET:    r = 1'b1;
         CMD_TOGGLE: r = ~q;
         default:    r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_neg_driver_if.sv
// Bus between the JK driver and the flop under test / controlling agent.
//   start            run request
//   Q, invQ          flop outputs being checked
//   invCP, invJ/invK generated clock and excitation
//   busy/done/pass/err/err_step/chk_cnt  run status
// slave  : the driver block
// master : the environment (flop model + controller)
interface jk_neg_driver_if;
   import jk_neg_driver_pkg::*;

   logic       start;
   logic       Q;
   logic       invQ;
   logic       invCP;
   logic       invJ;
   logic       invK;
   logic       busy;
   logic       done;
   logic       pass;
   logic       err;
   logic [2:0] err_step;
   logic [7:0] chk_cnt;

   modport slave (
      input  start, Q, invQ,
      output invCP, invJ, invK, busy, done, pass, err, err_step, chk_cnt
   );

   modport master (
      output start, Q, invQ,
      input  invCP, invJ, invK, busy, done, pass, err, err_step, chk_cnt
   );

endinterface

// File: rtl/jk_clk_div.sv
// Divider producing the active-low flop clock invCP.
//   CP       system clock
//   invCR    async active-low reset
//   en       run enable; when low invCP parks high and the divider holds 0
//   invCP    divided clock, first transition after enable is falling
//   fallStb  high in the cycle whose closing edge drives invCP 1->0
//   riseStb  high in the cycle whose closing edge drives invCP 0->1
module jk_clk_div
   import jk_neg_driver_pkg::*;
#(
   parameter int HALF_DIV = 2
) (
   input  logic CP,
   input  logic invCR,
   input  logic en,
   output logic invCP,
   output logic fallStb,
   output logic riseStb
);

   logic [7:0] div;
   logic       tick;

   assign tick    = en && (div == 8'(HALF_DIV - 1));
   assign fallStb = tick && invCP;
   assign riseStb = tick && !invCP;

   always_ff @(posedge CP or negedge invCR) begin
      if (!invCR) begin
         div   <= '0;
         invCP <= 1'b1;
      end else if (!en) begin
         div   <= '0;
         invCP <= 1'b1;
      end else if (tick) begin
         div   <= '0;
         invCP <= ~invCP;
      end else begin
         div   <= div + 8'd1;
      end
   end

endmodule

// File: rtl/jk_neg_driver.sv
// Exercises a negative-edge JK flop: generates invCP, walks the step table
// on invJ/invK, tracks the expected Q and checks Q/invQ on every rising
// invCP transition.
//   CP, invCR  clock and async active-low reset
//   bus        jk_neg_driver_if.slave (start, Q, invQ in; clock, excitation
//              and run status out)
module jk_neg_driver
   import jk_neg_driver_pkg::*;
#(
   parameter int HALF_DIV   = 2,
   parameter int STEP_EDGES = 2,
   parameter int LOOPS      = 2
) (
   input  logic              CP,
   input  logic              invCR,
   jk_neg_driver_if.slave    bus
);

   state_t     state, nextState;
   logic       accept, lastChk;
   logic       runEn, riseStb, fallStb, invCPw;
   logic [1:0] cmd;
   logic       expQ;
   logic [2:0] stepIdx;
   logic [3:0] loopCnt, edgeCnt;
   logic       err, pass, mismatch;
   logic [2:0] errStep;
   logic [7:0] chkCnt;
   logic       stepEnd, tableEnd, loopEnd;

   assign runEn = (state == RUN);

   jk_clk_div #(.HALF_DIV(HALF_DIV)) uDiv (
      .CP      (CP),
      .invCR   (invCR),
      .en      (runEn),
      .invCP   (invCPw),
      .fallStb (fallStb),
      .riseStb (riseStb)
   );

   assign stepEnd  = (edgeCnt == 4'(STEP_EDGES - 1));
   assign tableEnd = (stepIdx == 3'(STEP_LEN - 1));
   assign loopEnd  = (loopCnt == 4'(LOOPS - 1));
   assign mismatch = (bus.Q != expQ) || (bus.invQ == bus.Q);

   always_ff @(posedge CP or negedge invCR) begin
      if (!invCR) state <= IDLE;
      else        state <= nextState;
   end

   always_comb begin
      nextState = state;
      accept    = 1'b0;
      lastChk   = 1'b0;
      case (state)
         IDLE:   if (bus.start) begin
                    accept    = 1'b1;
                    nextState = RUN;
                 end
         RUN:    if (riseStb && stepEnd && tableEnd && loopEnd) begin
                    lastChk   = 1'b1;
                    nextState = FINISH;
                 end
         FINISH: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge CP or negedge invCR) begin
      if (!invCR) begin
         cmd     <= CMD_HOLD;
         expQ    <= 1'b0;
         stepIdx <= '0;
         loopCnt <= '0;
         edgeCnt <= '0;
         err     <= 1'b0;
         errStep <= '0;
         pass    <= 1'b0;
         chkCnt  <= '0;
      end else if (accept) begin
         cmd     <= stepCmd(3'd0);
         expQ    <= 1'b0;
         stepIdx <= '0;
         loopCnt <= '0;
         edgeCnt <= '0;
         err     <= 1'b0;
         pass    <= 1'b0;
         chkCnt  <= '0;
      end else if (fallStb) begin
         // The flop samples the command currently driven; cmd is stable here.
         expQ <= nextQ(cmd, expQ);
      end else if (riseStb) begin
         err <= err | mismatch;
         if (mismatch && !err) errStep <= stepIdx;
         if (chkCnt != 8'hFF) chkCnt <= chkCnt + 8'd1;
         if (lastChk) pass <= !(err | mismatch);
         // Command changes only here, half a period away from the sampling fall.
         if (stepEnd) begin
            edgeCnt <= '0;
            if (tableEnd) begin
               stepIdx <= '0;
               if (loopEnd) begin
                  loopCnt <= '0;
                  cmd     <= CMD_HOLD;
               end else begin
                  loopCnt <= loopCnt + 4'd1;
                  cmd     <= stepCmd(3'd0);
               end
            end else begin
               stepIdx <= stepIdx + 3'd1;
               cmd     <= stepCmd(3'(stepIdx + 3'd1));
            end
         end else begin
            edgeCnt <= edgeCnt + 4'd1;
         end
      end
   end

   assign bus.invCP    = invCPw;
   assign bus.invJ     = cmd[1];
   assign bus.invK     = cmd[0];
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == FINISH);
   assign bus.pass     = pass;
   assign bus.err      = err;
   assign bus.err_step = errStep;
   assign bus.chk_cnt  = chkCnt;

endmodule
